// File: rtl/uart_cmd_assembler.sv
// Assembles BYTES_PER_CMD received UART bytes (MSB first) into one command word,
// handed to the command processor through a cmd_rdy / clr_cmd_rdy handshake.
module uart_cmd_assembler #(
  parameter int BYTES_PER_CMD  = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_rdy,
  input  logic [7:0]                 rx_data,
  output logic                       clr_rdy,
  output logic [8*BYTES_PER_CMD-1:0] cmd,
  output logic                       cmd_rdy,
  input  logic                       clr_cmd_rdy,
  output logic                       overrun,
  output logic                       timeout_err
);

  localparam int CW = $clog2(BYTES_PER_CMD);
  localparam int SW = 8 * (BYTES_PER_CMD - 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES_PER_CMD - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              count_q, count_d;
  logic [SW-1:0]              shift_q, shift_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [8*BYTES_PER_CMD-1:0] cmd_q, cmd_d;
  logic                       cmd_rdy_q, cmd_rdy_d;
  logic                       overrun_q, overrun_d;
  logic                       timeout_q, timeout_d;
  logic                       complete;
  logic [SW-1:0]              shift_in;

  // Every byte is consumed in the cycle it is offered, so the ack is just rdy.
  assign clr_rdy  = rx_rdy & ~rst;
  assign shift_in = (shift_q << 8) | SW'(rx_data);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    timer_d   = timer_q;
    cmd_d     = cmd_q;
    complete  = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          shift_d = shift_in;
          count_d = CW'(1);
          timer_d = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_rdy) begin
          timer_d = '0;
          if (count_q == LAST_BYTE) begin
            cmd_d    = {shift_q, rx_data};
            complete = 1'b1;
            count_d  = '0;
            state_d  = IDLE;
          end else begin
            shift_d = shift_in;
            count_d = count_q + CW'(1);
          end
        end else if (timer_q == TIMER_MAX) begin
          // Stalled partial command: drop it so the next byte starts a fresh word.
          count_d   = '0;
          timer_d   = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion beats an ack in the same cycle; an unacked word being replaced is an overrun.
    cmd_rdy_d = complete | (cmd_rdy_q & ~clr_cmd_rdy);
    overrun_d = complete & cmd_rdy_q & ~clr_cmd_rdy;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      timer_q   <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      timer_q   <= timer_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign cmd         = cmd_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: directed scenarios on 2-byte and 3-byte instances plus
// randomized traffic compared cycle by cycle against a byte-queue reference model.
module tb_uart_cmd_assembler;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clr_cmd_rdy = 1'b0;

  logic        clr_rdy2, cmd_rdy2, ovr2, to2;
  logic [15:0] cmd2;
  logic        clr_rdy3, cmd_rdy3, ovr3, to3;
  logic [23:0] cmd3;

  int n_tests = 0;
  int n_fail  = 0;
  int clr_cnt = 0;

  always #5 clk = ~clk;

  uart_cmd_assembler #(.BYTES_PER_CMD(2), .TIMEOUT_CYCLES(TO)) dut2 (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rdy(clr_rdy2),
    .cmd(cmd2), .cmd_rdy(cmd_rdy2), .clr_cmd_rdy(clr_cmd_rdy), .overrun(ovr2),
    .timeout_err(to2));

  uart_cmd_assembler #(.BYTES_PER_CMD(3), .TIMEOUT_CYCLES(TO)) dut3 (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rdy(clr_rdy3),
    .cmd(cmd3), .cmd_rdy(cmd_rdy3), .clr_cmd_rdy(clr_cmd_rdy), .overrun(ovr3),
    .timeout_err(to3));

  always @(posedge clk) if (clr_rdy2) clr_cnt <= clr_cnt + 1;

  // Reference model: counts bytes gathered and idle cycles since the last byte.
  typedef struct {
    int          n;
    int          idle;
    logic [31:0] acc;
    logic [31:0] cmd;
    logic        rdy;
    logic        ovr;
    logic        to;
  } model_t;

  model_t m2, m3;

  function automatic model_t model_reset();
    model_t m;
    m.n = 0; m.idle = 0; m.acc = '0; m.cmd = '0; m.rdy = 0; m.ovr = 0; m.to = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m_in, int bpc, logic v, logic [7:0] d, logic clr);
    model_t m = m_in;
    logic [31:0] mask = (32'h1 << (8 * bpc)) - 32'h1;
    m.ovr = 0;
    m.to  = 0;
    if (v) begin
      m.acc  = (m.acc << 8) | {24'h0, d};
      m.n    = m.n + 1;
      m.idle = 0;
      if (m.n == bpc) begin
        m.cmd = m.acc & mask;
        m.ovr = m.rdy & ~clr;
        m.rdy = 1'b1;
        m.n   = 0;
        m.acc = '0;
      end else begin
        m.rdy = m.rdy & ~clr;
      end
    end else begin
      m.rdy = m.rdy & ~clr;
      if (m.n > 0) begin
        m.idle = m.idle + 1;
        if (m.idle == TO) begin
          m.n = 0; m.acc = '0; m.idle = 0; m.to = 1'b1;
        end
      end
    end
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m2 = model_reset();
      m3 = model_reset();
    end else begin
      m2 = model_step(m2, 2, rx_rdy, rx_data, clr_cmd_rdy);
      m3 = model_step(m3, 3, rx_rdy, rx_data, clr_cmd_rdy);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic ack();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rx_rdy = 1'b1;
    rx_data = 8'hFF;
    repeat (2) tick();
    n_tests++;
    if ({clr_rdy2, clr_rdy3} !== 2'b00) begin
      n_fail++; $display("FAIL reset_clr_rdy: got %b%b want 00", clr_rdy2, clr_rdy3);
    end
    n_tests++;
    if ({cmd2, cmd_rdy2, ovr2, to2, cmd3, cmd_rdy3, ovr3, to3} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got cmd2=%h rdy2=%b cmd3=%h rdy3=%b want 0",
                         cmd2, cmd_rdy2, cmd3, cmd_rdy3);
    end
    rx_rdy = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int c0 = clr_cnt;
    send(8'hA5);
    tick();
    n_tests++;
    if (cmd_rdy2 !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_rdy: got %b want 0", cmd_rdy2);
    end
    send(8'h3C);
    n_tests++;
    if (cmd2 !== 16'hA53C || cmd_rdy2 !== 1'b1) begin
      n_fail++; $display("FAIL basic_cmd: got %h/%b want a53c/1", cmd2, cmd_rdy2);
    end
    n_tests++;
    if (clr_cnt - c0 != 2) begin
      n_fail++; $display("FAIL basic_clr_rdy_pulses: got %0d want 2", clr_cnt - c0);
    end
    ack();
    n_tests++;
    if (cmd_rdy2 !== 1'b0 || cmd2 !== 16'hA53C) begin
      n_fail++; $display("FAIL basic_ack: got %h/%b want a53c/0", cmd2, cmd_rdy2);
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int first  = -1;
    send(8'h12);
    for (int k = 1; k <= TO + 5; k++) begin
      tick();
      if (to2 === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    n_tests++;
    if (pulses != 1 || first != TO) begin
      n_fail++; $display("FAIL timeout_pulse: got %0d pulses at %0d want 1 at %0d", pulses, first, TO);
    end
    n_tests++;
    if (cmd_rdy2 !== 1'b0) begin
      n_fail++; $display("FAIL timeout_no_cmd: got rdy=%b want 0", cmd_rdy2);
    end
    send(8'h34);
    tick();
    send(8'h56);
    n_tests++;
    if (cmd2 !== 16'h3456 || cmd_rdy2 !== 1'b1) begin
      n_fail++; $display("FAIL timeout_resync: got %h/%b want 3456/1", cmd2, cmd_rdy2);
    end
    ack();
  endtask

  task automatic test_timeout_boundary();
    int pulses = 0;
    send(8'h9A);
    repeat (TO - 1) begin
      tick();
      if (to2 === 1'b1) pulses++;
    end
    send(8'hBC);
    if (to2 === 1'b1) pulses++;
    n_tests++;
    if (pulses != 0 || cmd2 !== 16'h9ABC || cmd_rdy2 !== 1'b1) begin
      n_fail++; $display("FAIL timeout_edge: got %0d pulses cmd=%h/%b want 0 9abc/1",
                         pulses, cmd2, cmd_rdy2);
    end
    ack();
  endtask

  task automatic test_overrun();
    send(8'h11); tick(); send(8'h22);
    n_tests++;
    if (ovr2 !== 1'b0) begin
      n_fail++; $display("FAIL overrun_first: got %b want 0", ovr2);
    end
    tick(); send(8'h33); tick(); send(8'h44);
    n_tests++;
    if (ovr2 !== 1'b1 || cmd2 !== 16'h3344 || cmd_rdy2 !== 1'b1) begin
      n_fail++; $display("FAIL overrun_pulse: got ovr=%b cmd=%h/%b want 1 3344/1", ovr2, cmd2, cmd_rdy2);
    end
    tick();
    n_tests++;
    if (ovr2 !== 1'b0) begin
      n_fail++; $display("FAIL overrun_width: got %b want 0", ovr2);
    end
  endtask

  task automatic test_ack_collision();
    send(8'hBE);
    tick();
    clr_cmd_rdy = 1'b1;
    send(8'hEF);
    clr_cmd_rdy = 1'b0;
    n_tests++;
    if (cmd_rdy2 !== 1'b1 || cmd2 !== 16'hBEEF || ovr2 !== 1'b0) begin
      n_fail++; $display("FAIL ack_collision: got %h/%b ovr=%b want beef/1 ovr=0", cmd2, cmd_rdy2, ovr2);
    end
    ack();
  endtask

  task automatic test_mid_reset();
    send(8'h77);
    tick();
    rx_rdy = 1'b1;
    rx_data = 8'h88;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({clr_rdy2, cmd2, cmd_rdy2, ovr2, to2} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got clr=%b cmd=%h rdy=%b want 0", clr_rdy2, cmd2, cmd_rdy2);
    end
    tick();
    rx_rdy = 1'b0;
    rst = 1'b0;
    tick();
    send(8'hC0);
    tick();
    send(8'hDE);
    n_tests++;
    if (cmd2 !== 16'hC0DE || cmd_rdy2 !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_resync: got %h/%b want c0de/1", cmd2, cmd_rdy2);
    end
    ack();
  endtask

  task automatic test_bpc3();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send(8'h01); tick(); send(8'h02);
    n_tests++;
    if (cmd_rdy3 !== 1'b0) begin
      n_fail++; $display("FAIL bpc3_early_rdy: got %b want 0", cmd_rdy3);
    end
    tick(); send(8'h03);
    n_tests++;
    if (cmd3 !== 24'h010203 || cmd_rdy3 !== 1'b1) begin
      n_fail++; $display("FAIL bpc3_cmd: got %h/%b want 010203/1", cmd3, cmd_rdy3);
    end
    ack();
  endtask

  task automatic test_random();
    int silence = 0;
    int errs = 0;
    for (int i = 0; i < 1500; i++) begin
      if (silence > 0) begin
        silence--;
        rx_rdy = 1'b0;
      end else if ($urandom_range(0, 49) == 0) begin
        silence = $urandom_range(TO - 2, TO + 6);
        rx_rdy = 1'b0;
      end else begin
        rx_rdy = ($urandom_range(0, 2) == 0);
      end
      rx_data = 8'($urandom);
      clr_cmd_rdy = ($urandom_range(0, 3) == 0);
      tick();
      n_tests++;
      if ({cmd2, cmd_rdy2, ovr2, to2} !== {m2.cmd[15:0], m2.rdy, m2.ovr, m2.to} ||
          {cmd3, cmd_rdy3, ovr3, to3} !== {m3.cmd[23:0], m3.rdy, m3.ovr, m3.to}) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random_cycle_%0d: got %h %b%b%b / %h %b%b%b want %h %b%b%b / %h %b%b%b", i,
                   cmd2, cmd_rdy2, ovr2, to2, cmd3, cmd_rdy3, ovr3, to3,
                   m2.cmd[15:0], m2.rdy, m2.ovr, m2.to, m3.cmd[23:0], m3.rdy, m3.ovr, m3.to);
        errs++;
      end
    end
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_timeout();
    test_timeout_boundary();
    test_overrun();
    test_ack_collision();
    test_mid_reset();
    test_bpc3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
